// File: rtl/mux_share_arbiter_if.sv
// Bus bundle for mux_share_arbiter: requester side (req/data_in) and the
// arbitrated output stream. "slave" is the arbiter's view, "master" the requesters'.
interface mux_share_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       grant;
  logic [SELW-1:0]    address;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               busy;

  modport master (
    output req, data_in,
    input  grant, address, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req, data_in,
    output grant, address, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared N-to-1 data mux with a registered output stream.
// Optional ARB_BURST_LIMIT_EN forces rotation after MAX_BURST grant cycles when others wait.
module mux_share_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                reset_n,
  mux_share_arbiter_if.slave bus
);
  localparam int SELW = $clog2(N);

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q, state_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [SELW-1:0]  addr_q, addr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  src_q, src_d;

  logic             owner_req;
  logic             others_req;
  logic             burst_hit;
  logic             rearb;
  logic             found;
  logic [SELW-1:0]  win;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNTW = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
  logic [CNTW-1:0]  cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // First set request at or above ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = SELW'(idx);
      end
    end
  end

  always_comb begin
    owner_req  = bus.req[addr_q];
    others_req = |(bus.req & ~grant_q);
`ifdef ARB_BURST_LIMIT_EN
    burst_hit  = (state_q == OWN) && (cnt_q == CNT_LAST) && others_req;
`else
    burst_hit  = 1'b0;
`endif
    rearb = (state_q == IDLE) || !owner_req || burst_hit;

    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    if (rearb) begin
      if (found) begin
        state_d = OWN;
        addr_d  = win;
        grant_d = N'(1) << win;
        ptr_d   = (int'(win) == N - 1) ? '0 : win + 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        cnt_d   = '0;
`endif
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end else begin
`ifdef ARB_BURST_LIMIT_EN
      // Saturate so a lone owner keeps the grant without wrapping the count.
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_comb begin
    valid_d = (state_q == OWN) && owner_req;
    data_d  = data_q;
    src_d   = src_q;
    if (valid_d) begin
      data_d = bus.data_in[int'(addr_q)*WIDTH +: WIDTH];
      src_d  = addr_q;
    end

    bus.grant     = grant_q;
    bus.address   = addr_q;
    bus.out_valid = valid_q;
    bus.out_data  = data_q;
    bus.out_src   = src_q;
    bus.busy      = (state_q == OWN);
  end

  // Sole consumer of others_req when the burst limit is compiled out.
  logic unused_ok;
  assign unused_ok = others_req;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed + randomized bench for mux_share_arbiter against an index-based
// round-robin model; honours ARB_BURST_LIMIT_EN the same way as the design.
module tb_mux_share_arbiter;
  localparam int N         = 4;
  localparam int W         = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset_n;

  mux_share_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  mux_share_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = nobody), rotation start, burst length.
  int         m_owner;
  int         m_ptr;
  int         m_run;
  logic       m_valid;
  logic [W-1:0] m_data;
  int         m_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_run   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] d);
    bit           give_up;
    int           pick;
    logic [N-1:0] others;
    if (m_owner >= 0 && r[m_owner]) begin
      m_valid = 1'b1;
      m_data  = d[m_owner*W +: W];
      m_src   = m_owner;
    end else begin
      m_valid = 1'b0;
    end
    give_up = (m_owner < 0) || !r[m_owner];
`ifdef ARB_BURST_LIMIT_EN
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    if (m_owner >= 0 && m_run == MAX_BURST - 1 && others != 0) give_up = 1'b1;
`else
    others = '0;
`endif
    if (give_up) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && r[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      m_owner = pick;
      if (pick >= 0) begin
        m_ptr = (pick + 1) % N;
        m_run = 0;
      end
    end else if (m_run < MAX_BURST - 1) begin
      m_run++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, ".grant"},     32'(bus.grant),     32'(eg));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_owner >= 0));
    if (m_owner >= 0) chk({tag, ".address"}, 32'(bus.address), 32'(m_owner));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".out_src"},   32'(bus.out_src),   32'(m_src));
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.data_in[i*W +: W] = W'($urandom);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(bus.req, bus.data_in);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int rr_words;
    model_reset();
    reset_n     = 1'b0;
    bus.req     = 4'b1111;
    rand_data();

    // Held in reset with all requests pending.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant",     32'(bus.grant),     32'h0);
    chk("rst.address",   32'(bus.address),   32'h0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst.out_data",  32'(bus.out_data),  32'h0);
    chk("rst.out_src",   32'(bus.out_src),   32'h0);
    chk("rst.busy",      32'(bus.busy),      32'h0);

    reset_n = 1'b1;
    step("rel1");
    chk("rel1.grant_is_0", 32'(bus.grant), 32'h1);
    step("rel2");
    chk("rel2.first_word", 32'(bus.out_data), 32'(bus.data_in[0 +: W]));

    // Single requester 2 with a fixed word.
    bus.req = 4'b0100;
    bus.data_in[2*W +: W] = 8'hA5;
    repeat (4) step("single");
    chk("single.address", 32'(bus.address), 32'd2);
    chk("single.data",    32'(bus.out_data), 32'hA5);
    chk("single.src",     32'(bus.out_src),  32'd2);

    // All requesting; the owner drops its request for one cycle after 3 words.
    rr_words = 0;
    for (int c = 0; c < 24; c++) begin
      rand_data();
      bus.req = 4'b1111;
      if (m_owner >= 0 && rr_words == 3) begin
        bus.req[m_owner] = 1'b0;
        rr_words = 0;
      end
      step("rr");
      if (m_valid) rr_words++;
    end

    // Two requesters held: rotation only under the burst limit.
    bus.req = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      step("pair");
    end
    bus.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      step("lone");
    end
    chk("lone.grant", 32'(bus.grant), 32'h1);

    // Random traffic with sticky requests.
    for (int c = 0; c < 400; c++) begin
      rand_data();
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) bus.req[i] = ~bus.req[i];
      step("rand");
    end

    // Requester 1 streaming, then reset pulsed between edges.
    bus.req = 4'b0010;
    repeat (4) step("own1");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.grant",     32'(bus.grant),     32'h0);
    chk("arst.out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst.busy",      32'(bus.busy),      32'h0);
    chk("arst.out_data",  32'(bus.out_data),  32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    bus.req = 4'b1111;
    rand_data();
    step("restart");
    chk("restart.grant", 32'(bus.grant), 32'h1);
    step("restart2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Round-robin arbiter that shares one N-to-1 data multiplexer between N requesters. It picks one owner from the active requests, drives the multiplexer select, and registers the selected word onto a single output channel. Downstream logic sees one stream plus the index of the requester that produced each word.

## Interface
- N, 4, number of requesters (2..16)
- WIDTH, 8, data width per requester
- MAX_BURST, 4, grant cycles before forced rotation (only with ARB_BURST_LIMIT_EN; ≥1)
- SELW, $clog2(N), select width (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  N  request per requester, level-sensitive
- data_in  input  N*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- grant  output  N  one-hot current owner, registered
- address  output  SELW  multiplexer select = index of owner, registered
- out_valid  output  1  out_data holds a granted word
- out_data  output  WIDTH  registered multiplexer output
- out_src  output  SELW  requester index that produced out_data
- busy  output  1  a grant is active

## Operation
- Two states:
  - IDLE: no owner.
  - OWN: owner = address, grant[address] = 1.
- Rotation pointer ptr resets to 0.
- Arbitration at every edge where the state is IDLE or the owner releases:
  - Search req from index ptr upward, wrapping mod N. The first set bit becomes the owner.
  - If no bit is set, go to IDLE.
- Release conditions:
  - req[owner] is low, or
  - the burst limit fires (see Configuration).
- Re-arbitration happens on the same edge as the release. There is no idle bubble between owners.
- On every transition to a new owner: ptr ← new owner + 1 mod N. The new owner therefore has lowest priority at the next arbitration.
- Re-granting the same requester is allowed if it is the only request.
- Data path, each edge:
  - In OWN with req[owner] high: out_data ← data_in[owner], out_src ← owner, out_valid ← 1.
  - Otherwise: out_valid ← 0. out_data and out_src hold their last value.
- busy = (state == OWN).
- Reset (reset_n low, asynchronous):
  - State IDLE, ptr 0.
  - grant 0, address 0, out_valid 0, out_data 0, out_src 0, busy 0.
- Reset asserted mid-grant drops the grant immediately. No word is emitted in the cycle reset deasserts.
- Requests arriving while another requester owns the multiplexer wait. They cannot preempt the owner.

## Timing
- req[i] first sampled high at edge E0 from IDLE:
  - grant and address valid after E0.
  - First word (data_in sampled at E1) appears on out_data after E1.
  - Request-to-data latency: 2 edges.
- Owner drops req, sampled at edge Ek:
  - grant moves to the next requester after Ek, or clears if none.
  - The word captured at Ek has out_valid = 0.
- Steady ownership: one word per cycle, throughput 1.
- grant and address never change except at a clock edge or on asynchronous reset.
- grant is always one-hot or zero.

## Configuration
- ARB_BURST_LIMIT_EN defined:
  - A burst counter starts at 0 on each new grant and increments each OWN cycle.
  - When the counter equals MAX_BURST-1 and any req[j] (j ≠ owner) is high, the owner is released at that edge. Arbitration then starts from owner+1.
  - If no other request is pending, the counter saturates and the owner keeps the grant.
- ARB_BURST_LIMIT_EN undefined:
  - No counter.
  - The owner holds the grant until its req drops. Fairness relies on requesters releasing.

## Test plan
- Reset: hold reset_n = 0 with req = 4'b1111 → grant = 0, address = 0, out_valid = 0, out_data = 0, busy = 0. Release → grant = 4'b0001 after the first edge, out_data = data_in[0] after the second.
- Single requester: req = 4'b0100, data_in[2] = 8'hA5 → address = 2, out_valid = 1, out_data = 8'hA5, out_src = 2 from edge 2 onward.
- Round-robin: req = 4'b1111, each requester drops req for one cycle after 3 words → grant order 0, 1, 2, 3, 0 with no idle cycle between owners.
- Burst limit (macro on, MAX_BURST = 4): req = 4'b0011 held constant → grant alternates 0, 1, 0, every 4 cycles. With req = 4'b0001 only, grant stays 0 indefinitely.
- Burst limit off, same stimulus req = 4'b0011 held → grant stays 4'b0001 forever.
- Mid-grant reset: owner 1 streaming, pulse reset_n low between edges → grant, out_valid and busy drop to 0 asynchronously. After release, arbitration restarts from ptr = 0.
